// File: rtl/alu_exec_seq.sv
// Execute unit: RV32I ALU ops, branch compare and RV32M multiply/divide.
// Latency: 1 cycle for single-cycle and illegal ops, XLEN+1 cycles for M ops.
// Backpressure: the result holds in DONE until out_ready; in_ready is low while iterating.
module alu_exec_seq #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1,
  parameter int SHW      = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      aluop,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            cmp_true,
  output logic            illegal,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;

  // Decode outputs for the op currently offered
  logic [XLEN-1:0] dec_result;
  logic            dec_cmp;
  logic            dec_illegal;
  logic            dec_is_m;

  // Iterative datapath: hi/lo double as product (mul) or remainder/quotient (div)
  logic [XLEN-1:0] hi, lo, mcand, a_raw;
  logic [2:0]      m_f3;
  logic            res_neg;   // product or quotient must be negated at the end
  logic            rem_neg;   // remainder takes the dividend's sign
  logic            div_zero;
  logic [SHW-1:0]  cnt;
  logic            last_iter;

  logic [XLEN-1:0] step_hi, step_lo, m_result;

  assign accept    = in_valid & in_ready;
  assign last_iter = (cnt == SHW'(XLEN - 1));

  // Single-cycle decode and compute
  always_comb begin
    logic [XLEN-1:0] sum, diff;
    logic [SHW-1:0]  shamt;
    logic            lt_s, lt_u, use_base, alt;
    dec_result  = '0;
    dec_cmp     = 1'b0;
    dec_illegal = 1'b0;
    dec_is_m    = 1'b0;
    use_base    = 1'b0;
    alt         = 1'b0;
    sum   = op_a + op_b;
    diff  = op_a - op_b;
    shamt = op_b[SHW-1:0];
    lt_s  = $signed(op_a) < $signed(op_b);
    lt_u  = op_a < op_b;
    case (aluop)
      3'b000: begin
        if (funct7 == 7'b0000000) begin
          use_base = 1'b1;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000 || funct3 == 3'b101) begin
            use_base = 1'b1;
            alt      = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (funct7 == 7'b0000001) begin
          if (ENABLE_M) dec_is_m = 1'b1;
          else          dec_illegal = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      3'b110: begin
        // I-type has no subtract; funct7 is immediate bits except for shifts
        if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
          dec_illegal = 1'b1;
        end else begin
          use_base = 1'b1;
          alt      = (funct3 == 3'b101) & funct7[5];
        end
      end
      3'b001, 3'b010, 3'b111: dec_result = sum;
      3'b011: begin
        dec_result = diff;
        case (funct3)
          3'b000:  dec_cmp = (op_a == op_b);
          3'b001:  dec_cmp = (op_a != op_b);
          3'b100:  dec_cmp = lt_s;
          3'b101:  dec_cmp = ~lt_s;
          3'b110:  dec_cmp = lt_u;
          3'b111:  dec_cmp = ~lt_u;
          default: dec_illegal = 1'b1;
        endcase
      end
      3'b101: dec_result = '0;
      default: dec_illegal = 1'b1;
    endcase
    if (use_base) begin
      case (funct3)
        3'b000:  dec_result = alt ? diff : sum;
        3'b001:  dec_result = op_a << shamt;
        3'b010:  dec_result = {{(XLEN-1){1'b0}}, lt_s};
        3'b011:  dec_result = {{(XLEN-1){1'b0}}, lt_u};
        3'b100:  dec_result = op_a ^ op_b;
        3'b101:  dec_result = alt ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
        3'b110:  dec_result = op_a | op_b;
        default: dec_result = op_a & op_b;
      endcase
    end
    if (dec_illegal) begin
      dec_result = '0;
      dec_cmp    = 1'b0;
    end
  end

  // One shift-add (mul) or restoring-subtract (div) step, plus the final sign fix
  always_comb begin
    logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   quo, rmd;
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    rem_sh  = {hi, lo[XLEN-1]};
    rem_sub = rem_sh - {1'b0, mcand};
    if (m_f3[2]) begin
      if (!rem_sub[XLEN]) begin
        step_hi = rem_sub[XLEN-1:0];
        step_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[XLEN-1:0];
        step_lo = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod   = {step_hi, step_lo};
    prod_f = res_neg ? -prod : prod;
    quo    = div_zero ? '1    : (res_neg ? -step_lo : step_lo);
    rmd    = div_zero ? a_raw : (rem_neg ? -step_hi : step_hi);
    if (m_f3[2])                m_result = m_f3[1] ? rmd : quo;
    else if (m_f3[1:0] == 2'b00) m_result = prod_f[XLEN-1:0];
    else                         m_result = prod_f[2*XLEN-1:XLEN];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = dec_is_m ? ITER : DONE;
      ITER: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = accept ? (dec_is_m ? ITER : DONE) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    out_valid = (state == DONE);
    busy      = (state == ITER);
  end

  // Operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      cmp_true <= 1'b0;
      illegal  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      m_f3     <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      if (dec_is_m) begin
        logic a_sgn, b_sgn, a_neg, b_neg;
        logic [XLEN-1:0] mag_a, mag_b;
        a_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        b_sgn = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
        a_neg = a_sgn & op_a[XLEN-1];
        b_neg = b_sgn & op_b[XLEN-1];
        mag_a = a_neg ? -op_a : op_a;
        mag_b = b_neg ? -op_b : op_b;
        m_f3     <= funct3;
        a_raw    <= op_a;
        hi       <= '0;
        lo       <= funct3[2] ? mag_a : mag_b;
        mcand    <= funct3[2] ? mag_b : mag_a;
        res_neg  <= a_neg ^ b_neg;
        rem_neg  <= a_neg;
        div_zero <= (op_b == '0);
        cnt      <= '0;
        result   <= '0;
        cmp_true <= 1'b0;
        illegal  <= 1'b0;
      end else begin
        result   <= dec_result;
        cmp_true <= dec_cmp;
        illegal  <= dec_illegal;
      end
    end else if (state == ITER) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + 1'b1;
      if (last_iter) result <= m_result;
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: one ENABLE_M=1 and one ENABLE_M=0 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed constants.
module tb_alu_exec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2, out_ready;
  logic [2:0]  aluop, funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b;

  logic        in_ready, out_valid, cmp_true, illegal, busy;
  logic [31:0] result;
  logic        in_ready2, out_valid2, cmp_true2, illegal2, busy2;
  logic [31:0] result2;

  logic        sel;
  logic        o_valid, o_cmp, o_ill;
  logic [31:0] o_res;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign o_valid = sel ? out_valid2 : out_valid;
  assign o_cmp   = sel ? cmp_true2  : cmp_true;
  assign o_ill   = sel ? illegal2   : illegal;
  assign o_res   = sel ? result2    : result;

  alu_exec_seq #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cmp_true(cmp_true), .illegal(illegal), .busy(busy)
  );

  alu_exec_seq #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .aluop(aluop), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2),
    .cmp_true(cmp_true2), .illegal(illegal2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op (called just after a falling edge) and wait for out_valid.
  task automatic run_op(input bit s, input logic [2:0] aop, f3, input logic [6:0] f7,
                        input logic [31:0] a, b, output int lat);
    sel = s; aluop = aop; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    out_ready = 1'b0;
    if (s) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_valid2 = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit s, input logic [2:0] aop, f3,
                       input logic [6:0] f7, input logic [31:0] a, b, exp_r,
                       input logic exp_c, exp_i, input int exp_lat);
    int lat;
    run_op(s, aop, f3, f7, a, b, lat);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, 64'(o_res), 64'(exp_r));
    chk({tag, ".cmp"}, 64'(o_cmp), 64'(exp_c));
    chk({tag, ".ill"}, 64'(o_ill), 64'(exp_i));
    retire();
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0; sel = 1'b0;
    aluop = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result",    64'(result),    64'd0);
    chk("rst.cmp",       64'(cmp_true),  64'd0);
    chk("rst.illegal",   64'(illegal),   64'd0);
    chk("rst.busy",      64'(busy),      64'd0);

    // Back-to-back add then sub with out_ready held high
    aluop = 3'b000; funct3 = 3'b000; funct7 = 7'b0000000; op_a = 32'd5; op_b = 32'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("b2b.add.vld", 64'(out_valid), 64'd1);
    chk("b2b.add.res", 64'(result), 64'd12);
    chk("b2b.rdy",     64'(in_ready), 64'd1);
    funct7 = 7'b0100000; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b.sub.vld", 64'(out_valid), 64'd1);
    chk("b2b.sub.res", 64'(result), 64'hFFFF_FFFE);
    @(negedge clk);
    chk("b2b.idle", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // RV32I register and immediate ops
    do_op("sll",    0, 3'b000, 3'b001, 7'h00, 32'h1,         32'd35,        32'h8,         0, 0, 1);
    do_op("slt",    0, 3'b000, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 1);
    do_op("sltu",   0, 3'b000, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0, 1);
    do_op("xor",    0, 3'b000, 3'b100, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0, 0, 1);
    do_op("srl",    0, 3'b000, 3'b101, 7'h00, 32'h8000_0000, 32'h4,         32'h0800_0000, 0, 0, 1);
    do_op("sra",    0, 3'b000, 3'b101, 7'h20, 32'h8000_0000, 32'h4,         32'hF800_0000, 0, 0, 1);
    do_op("or",     0, 3'b000, 3'b110, 7'h00, 32'hF0,        32'h0F,        32'hFF,        0, 0, 1);
    do_op("and",    0, 3'b000, 3'b111, 7'h00, 32'hF0,        32'h3C,        32'h30,        0, 0, 1);
    do_op("alt.f3", 0, 3'b000, 3'b001, 7'h20, 32'h1,         32'h1,         32'h0,         0, 1, 1);
    do_op("bad.f7", 0, 3'b000, 3'b000, 7'h02, 32'h1,         32'h1,         32'h0,         0, 1, 1);
    do_op("addi",   0, 3'b110, 3'b000, 7'h7F, 32'd10,        32'hFFFF_FFFF, 32'd9,         0, 0, 1);
    do_op("slli.b", 0, 3'b110, 3'b001, 7'h01, 32'h1,         32'h1,         32'h0,         0, 1, 1);
    do_op("srai",   0, 3'b110, 3'b101, 7'h20, 32'h8000_0000, 32'h404,       32'hF800_0000, 0, 0, 1);
    do_op("load",   0, 3'b001, 3'b010, 7'h00, 32'd100,       32'hFFFF_FFFC, 32'd96,        0, 0, 1);
    do_op("jal",    0, 3'b101, 3'b000, 7'h00, 32'h1234,      32'h8,         32'h0,         0, 0, 1);
    do_op("rsvd",   0, 3'b100, 3'b000, 7'h00, 32'h1,         32'h2,         32'h0,         0, 1, 1);

    // Branch compares
    do_op("blt",  0, 3'b011, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 1, 0, 1);
    do_op("bltu", 0, 3'b011, 3'b110, 7'h00, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 0, 0, 1);
    do_op("b010", 0, 3'b011, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 1, 1);
    do_op("beq",  0, 3'b011, 3'b000, 7'h00, 32'h5,         32'h5,         32'h0,         1, 0, 1);
    do_op("bge",  0, 3'b011, 3'b101, 7'h00, 32'h1,         32'hFFFF_FFFF, 32'h2,         1, 0, 1);

    // Multiply
    do_op("mul",    0, 3'b000, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 0, 0, 33);
    do_op("mulhu",  0, 3'b000, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'h2,         32'h1,         0, 0, 33);
    do_op("mulh",   0, 3'b000, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 0, 0, 33);
    do_op("mulhsu", 0, 3'b000, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 0, 0, 33);
    do_op("mulh.m", 0, 3'b000, 3'b001, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0, 33);
    do_op("mul.lo", 0, 3'b000, 3'b000, 7'h01, 32'h1234_5678, 32'h10,        32'h2345_6780, 0, 0, 33);

    // Divide, including divide-by-zero and signed overflow
    do_op("div.z",  0, 3'b000, 3'b100, 7'h01, 32'd7,         32'd0,         32'hFFFF_FFFF, 0, 0, 33);
    do_op("rem.z",  0, 3'b000, 3'b110, 7'h01, 32'd7,         32'd0,         32'd7,         0, 0, 33);
    do_op("remu.z", 0, 3'b000, 3'b111, 7'h01, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0, 0, 33);
    do_op("div.ov", 0, 3'b000, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 33);
    do_op("rem.ov", 0, 3'b000, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         0, 0, 33);
    do_op("rem.n",  0, 3'b000, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 0, 33);
    do_op("div.n",  0, 3'b000, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0, 33);
    do_op("divu",   0, 3'b000, 3'b101, 7'h01, 32'd100,       32'd7,         32'd14,        0, 0, 33);
    do_op("remu",   0, 3'b000, 3'b111, 7'h01, 32'd100,       32'd7,         32'd2,         0, 0, 33);

    // Result holds while out_ready is low
    run_op(0, 3'b000, 3'b000, 7'h00, 32'h10, 32'h20, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.vld", 64'(out_valid), 64'd1);
      chk("hold.res", 64'(result),    64'h30);
      chk("hold.rdy", 64'(in_ready),  64'd0);
    end
    retire();

    // Reset in the middle of a divide
    sel = 1'b0; aluop = 3'b000; funct3 = 3'b101; funct7 = 7'h01;
    op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort.busy_pre", 64'(busy),     64'd1);
    chk("abort.rdy_pre",  64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.vld",  64'(out_valid), 64'd0);
    chk("abort.busy", 64'(busy),      64'd0);
    chk("abort.rdy",  64'(in_ready),  64'd1);
    chk("abort.res",  64'(result),    64'd0);
    repeat (40) @(negedge clk);
    chk("abort.late_vld", 64'(out_valid), 64'd0);
    chk("abort.late_res", 64'(result),    64'd0);

    // Build without M extension
    do_op("nom.mul",  1, 3'b000, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'h2,   32'h0,         0, 1, 1);
    do_op("nom.srai", 1, 3'b110, 3'b101, 7'h20, 32'h8000_0000, 32'h404, 32'hF800_0000, 0, 0, 1);
    chk("nom.busy", 64'(busy2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
